uart_rx_8n1: RTL and testbench

Standalone 8N1 UART receiver: it deserialises an asynchronous serial line into bytes, using mid-bit sampling derived from the system clock. It is the receive counterpart to the team's UART transmit path. It sits directly behind the board RX pin (12 MHz HSOSC domain) and feeds byte consumers or a loopback into the transmitter. It flags framing errors and glitched start bits, and can optionally buffer bytes in a FIFO.

---
 rtl/uart_rx_8n1_if.sv | 11 +
 rtl/uart_rx_8n1.sv | 122 ++++++++++++
 tb/tb_uart_rx_8n1.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_8n1_if.sv
// uart_rx_8n1_if: received-byte, status and consumer-ready signals of the 8N1 receiver
interface uart_rx_8n1_if;
  logic [7:0] o_rx_data;
  logic       o_rx_data_valid;
  logic       o_rx_frame_err;
  logic       o_rx_overrun;
  logic       o_rx_busy;
  logic       i_rx_ready;
  modport master (output o_rx_data, o_rx_data_valid, o_rx_frame_err, o_rx_overrun, o_rx_busy, input i_rx_ready);
  modport slave  (input o_rx_data, o_rx_data_valid, o_rx_frame_err, o_rx_overrun, o_rx_busy, output i_rx_ready);
endinterface

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 UART receiver with mid-bit sampling; define UART_RX_FIFO_EN for a FIFO_DEPTH-entry receive FIFO
module uart_rx_8n1 #(
  parameter int BAUDRATE   = 1250,
  parameter int FIFO_DEPTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_rx_serial,
  uart_rx_8n1_if.master rx
);
  localparam int HALF = BAUDRATE / 2;
  localparam int CW   = $clog2(BAUDRATE);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state;
  logic          s1, rxs, armed, accept;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  always_comb accept = state == STOP && cnt == CW'(BAUDRATE - 1) && rxs;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1                <= 1'b1;
      rxs               <= 1'b1;
      state             <= IDLE;
      armed             <= 1'b0;
      cnt               <= '0;
      bit_idx           <= '0;
      shift             <= '0;
      rx.o_rx_busy      <= 1'b0;
      rx.o_rx_frame_err <= 1'b0;
    end else begin
      s1                <= i_rx_serial;
      rxs               <= s1;
      rx.o_rx_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rxs) armed <= 1'b1;
          else if (armed) begin
            state        <= START;
            armed        <= 1'b0;
            rx.o_rx_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == CW'(HALF - 1)) begin
            cnt          <= '0;
            bit_idx      <= '0;
            state        <= rxs ? IDLE : DATA;
            armed        <= rxs;
            rx.o_rx_busy <= !rxs;
          end else cnt <= cnt + 1'b1;
        end
        DATA: begin
          if (cnt == CW'(BAUDRATE - 1)) begin
            cnt     <= '0;
            shift   <= {rxs, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else cnt <= cnt + 1'b1;
        end
        STOP: begin
          if (cnt == CW'(BAUDRATE - 1)) begin
            cnt               <= '0;
            state             <= IDLE;
            armed             <= rxs;
            rx.o_rx_busy      <= 1'b0;
            rx.o_rx_frame_err <= !rxs;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd, wr, rd_n;
  logic [AW:0]   level, level_pop, level_n;
  logic          pop, push;
  always_comb begin
    pop       = rx.o_rx_data_valid && rx.i_rx_ready;
    level_pop = level - {{AW{1'b0}}, pop};
    push      = accept && level_pop != FULL;
    level_n   = level_pop + {{AW{1'b0}}, push};
    rd_n      = rd + {{(AW-1){1'b0}}, pop};
  end
  always_ff @(posedge clk) if (push) mem[wr] <= shift;
  always_ff @(posedge clk) begin
    if (reset) begin
      rd                 <= '0;
      wr                 <= '0;
      level              <= '0;
      rx.o_rx_data       <= '0;
      rx.o_rx_data_valid <= 1'b0;
      rx.o_rx_overrun    <= 1'b0;
    end else begin
      if (push) wr <= wr + 1'b1;
      rd                 <= rd_n;
      level              <= level_n;
      rx.o_rx_data_valid <= level_n != '0;
      rx.o_rx_data       <= level_pop != '0 ? mem[rd_n] : push ? shift : rx.o_rx_data;
      rx.o_rx_overrun    <= accept && !push;
    end
  end
`else
  logic unused_ready;
  assign unused_ready = rx.i_rx_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      rx.o_rx_data       <= '0;
      rx.o_rx_data_valid <= 1'b0;
      rx.o_rx_overrun    <= 1'b0;
    end else begin
      rx.o_rx_data       <= accept ? shift : rx.o_rx_data;
      rx.o_rx_data_valid <= accept;
      rx.o_rx_overrun    <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: randomized frames against a queue-based model of the 8N1 receiver
module tb_uart_rx_8n1;
  localparam int BAUD = 16;
  localparam int HALF = BAUD / 2;
  logic clk = 1'b0, reset = 1'b1, rx_line = 1'b1;
  int vectors = 0, miscompares = 0;
  int ferr_cnt = 0, ferr_exp = 0, ovr_cnt = 0;
  logic [7:0] exp_q[$], got_q[$];
  uart_rx_8n1_if bus ();
  uart_rx_8n1 #(.BAUDRATE(BAUD), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .i_rx_serial(rx_line), .rx(bus.master)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (!reset) begin
`ifdef UART_RX_FIFO_EN
    if (bus.o_rx_data_valid && bus.i_rx_ready) got_q.push_back(bus.o_rx_data);
`else
    if (bus.o_rx_data_valid) got_q.push_back(bus.o_rx_data);
`endif
    if (bus.o_rx_frame_err) ferr_cnt++;
    if (bus.o_rx_overrun) ovr_cnt++;
  end
  task automatic send(input logic [7:0] b, input bit stop_ok, input int permille, input int nbits);
    logic [9:0] f;
    int prev, t;
    f = {stop_ok, b, 1'b0};
    prev = 0;
    for (int k = 0; k < nbits; k++) begin
      rx_line = f[k];
      t = (BAUD * (1000 + permille) * (k + 1) + 500) / 1000;
      repeat (t - prev) @(posedge clk);
      #1;
      prev = t;
    end
    rx_line = 1'b1;
    if (!stop_ok) begin
      repeat (BAUD) @(posedge clk);
      #1;
    end
  endtask
  task automatic frame(input logic [7:0] b, input bit stop_ok, input int permille);
    send(b, stop_ok, permille, 10);
    if (stop_ok) exp_q.push_back(b);
    else ferr_exp++;
  endtask
  task automatic settle(input string tag);
    repeat (3 * BAUD) @(posedge clk);
    #1;
    check({tag, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check({tag, " byte"}, got_q[i], exp_q[i]);
    check({tag, " ferr"}, ferr_cnt, ferr_exp);
    check({tag, " busy"}, bus.o_rx_busy, 0);
    got_q.delete();
    exp_q.delete();
    ferr_cnt = 0;
    ferr_exp = 0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bus.i_rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset data", bus.o_rx_data, 0);
    check("reset valid", bus.o_rx_data_valid, 0);
    check("reset ferr", bus.o_rx_frame_err, 0);
    check("reset ovr", bus.o_rx_overrun, 0);
    check("reset busy", bus.o_rx_busy, 0);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    fork
      frame(8'hA5, 1'b1, 0);
      begin
        repeat (HALF + 9 * BAUD + 2) @(posedge clk);
        #1;
        check("latency early", bus.o_rx_data_valid, 0);
        @(posedge clk);
        #1;
        check("latency valid", bus.o_rx_data_valid, 1);
        check("latency data", bus.o_rx_data, 8'hA5);
      end
    join
    settle("a5");
    rx_line = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("glitch busy", bus.o_rx_busy, 1);
    rx_line = 1'b1;
    repeat (HALF + 3 - 5) @(posedge clk);
    #1;
    check("glitch idle", bus.o_rx_busy, 0);
    settle("glitch");
    frame(8'h3C, 1'b0, 0);
    frame(8'h81, 1'b1, 0);
    settle("frame err");
    frame(8'h00, 1'b1, 30);
    frame(8'hFF, 1'b1, 30);
    frame(8'h55, 1'b1, 30);
    settle("back2back");
    repeat (10) begin
      frame(8'($urandom), $urandom_range(0, 4) != 0, int'($urandom_range(0, 60)) - 30);
      repeat ($urandom_range(0, 20)) @(posedge clk);
      #1;
    end
    settle("random");
    send(8'h7E, 1'b1, 0, 5);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midreset data", bus.o_rx_data, 0);
    check("midreset valid", bus.o_rx_data_valid, 0);
    check("midreset ferr", bus.o_rx_frame_err, 0);
    check("midreset busy", bus.o_rx_busy, 0);
    repeat (4) @(posedge clk);
    #1;
    frame(8'h42, 1'b1, 0);
    settle("midreset");
`ifdef UART_RX_FIFO_EN
    bus.i_rx_ready = 1'b0;
    ovr_cnt = 0;
    for (int b = 1; b <= 5; b++) begin
      send(8'(b), 1'b1, 0, 10);
      if (b <= 4) exp_q.push_back(8'(b));
    end
    repeat (2 * BAUD) @(posedge clk);
    #1;
    check("fifo overrun", ovr_cnt, 1);
    check("fifo full valid", bus.o_rx_data_valid, 1);
    check("fifo head", bus.o_rx_data, 8'h01);
    bus.i_rx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("fifo pop data", bus.o_rx_data, i);
      check("fifo pop valid", bus.o_rx_data_valid, 1);
    end
    @(negedge clk);
    check("fifo drained", bus.o_rx_data_valid, 0);
    settle("fifo");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
